// File: rtl/mem_sequencer.sv
// Memory-access sequencer: owns the PC and turns fetch/load/store requests into timed RAM command sequences.
// Optional MEM_SEQ_BOUNDS_EN adds the err port and suppresses accesses whose top address bit is set.
module mem_sequencer #(
   parameter int                ADDR_W   = 9,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_req,
   input  logic              ls_req,
   input  logic              ls_write,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_val,
   input  logic [DATA_W-1:0] read_data,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] write_data,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] ld_data,
   output logic              done,
   output logic              busy
`ifdef MEM_SEQ_BOUNDS_EN
  ,output logic              err
`endif
);

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_F1   = 3'd1,
      ST_F2   = 3'd2,
      ST_L1   = 3'd3,
      ST_L2   = 3'd4,
      ST_S1   = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

   state_t              state_r;
   logic [1:0]          mem_cmd_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [DATA_W-1:0]   write_data_r;
   logic [ADDR_W-1:0]   pc_r;
   logic [DATA_W-1:0]   instr_r;
   logic [DATA_W-1:0]   ld_data_r;
   logic                done_r;
   logic                busy_r;
   logic [ADDR_W-1:0]   pc_sel_s;
   logic                ls_bad_s;
   logic                fetch_bad_s;
`ifdef MEM_SEQ_BOUNDS_EN
   logic                err_r;
`endif

   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
      return p + {{(ADDR_W-1){1'b0}}, 1'b1};
   endfunction

   // PC seen by an IDLE-cycle fetch: a same-cycle pc_load bypasses the old value
   always_comb begin
      pc_sel_s = pc_r;
      if (pc_load) begin
         pc_sel_s = pc_load_val;
      end else begin
         pc_sel_s = pc_r;
      end
   end

`ifdef MEM_SEQ_BOUNDS_EN
   assign ls_bad_s    = ls_addr[ADDR_W-1];
   assign fetch_bad_s = pc_sel_s[ADDR_W-1];
`else
   assign ls_bad_s    = 1'b0;
   assign fetch_bad_s = 1'b0;
`endif

   // Sequencer FSM; every output is registered here
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         mem_cmd_r    <= CMD_NONE;
         mem_addr_r   <= RESET_PC;
         write_data_r <= {DATA_W{1'b0}};
         pc_r         <= RESET_PC;
         instr_r      <= {DATA_W{1'b0}};
         ld_data_r    <= {DATA_W{1'b0}};
         done_r       <= 1'b0;
         busy_r       <= 1'b0;
`ifdef MEM_SEQ_BOUNDS_EN
         err_r        <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
`ifdef MEM_SEQ_BOUNDS_EN
         err_r  <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
               pc_r       <= pc_sel_s;
               mem_addr_r <= pc_sel_s;
               mem_cmd_r  <= CMD_NONE;
               if (ls_req) begin
                  // mem_addr doubles as the latched load/store address
                  mem_addr_r <= ls_addr;
                  busy_r     <= 1'b1;
                  if (ls_bad_s) begin
                     state_r <= ST_ERR;
                  end else if (ls_write) begin
                     state_r      <= ST_S1;
                     mem_cmd_r    <= CMD_WRITE;
                     write_data_r <= ls_wdata;
                  end else begin
                     state_r   <= ST_L1;
                     mem_cmd_r <= CMD_READ;
                  end
               end else if (fetch_req) begin
                  busy_r <= 1'b1;
                  if (fetch_bad_s) begin
                     state_r <= ST_ERR;
                  end else begin
                     state_r   <= ST_F1;
                     mem_cmd_r <= CMD_READ;
                  end
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_F1: begin
               state_r <= ST_F2;
            end
            ST_F2: begin
               instr_r    <= read_data;
               pc_r       <= pc_inc(pc_r);
               mem_addr_r <= pc_inc(pc_r);
               mem_cmd_r  <= CMD_NONE;
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               done_r     <= 1'b1;
            end
            ST_L1: begin
               state_r <= ST_L2;
            end
            ST_L2: begin
               ld_data_r  <= read_data;
               mem_addr_r <= pc_r;
               mem_cmd_r  <= CMD_NONE;
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               done_r     <= 1'b1;
            end
            ST_S1: begin
               mem_addr_r <= pc_r;
               mem_cmd_r  <= CMD_NONE;
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               done_r     <= 1'b1;
            end
            ST_ERR: begin
               mem_addr_r <= pc_r;
               mem_cmd_r  <= CMD_NONE;
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               done_r     <= 1'b1;
`ifdef MEM_SEQ_BOUNDS_EN
               err_r      <= 1'b1;
`endif
            end
            default: begin
               mem_addr_r <= pc_r;
               mem_cmd_r  <= CMD_NONE;
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign mem_cmd    = mem_cmd_r;
   assign mem_addr   = mem_addr_r;
   assign write_data = write_data_r;
   assign pc         = pc_r;
   assign instr      = instr_r;
   assign ld_data    = ld_data_r;
   assign done       = done_r;
   assign busy       = busy_r;
`ifdef MEM_SEQ_BOUNDS_EN
   assign err        = err_r;
`endif

endmodule
